cdc_hs_tx: RTL and testbench



---
 rtl/cdc_pkg.sv | 13 +
 rtl/cdc_sync_sreset.sv | 28 ++
 rtl/cdc_hs_tx.sv | 89 ++++++++
 tb/tb_cdc_hs_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the 4-phase req/ack CDC transmitter and its matching receiver.
package cdc_pkg;

    localparam int unsigned CDC_PS_DEFAULT = 2;
    localparam int unsigned CDC_DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } cdc_state_e;

endpackage

// File: rtl/cdc_sync_sreset.sv
// PS-stage single-bit level synchronizer with synchronous active-high reset.
module cdc_sync_sreset #(
    parameter int unsigned PS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [PS-1:0] sync_q;
    logic [PS-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[PS-2:0], din};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[PS-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a 4-phase req/ack handshake: captures a word, raises req, waits for
// the synchronized ack to rise and then fall, and pulses done when the cycle closes.
module cdc_hs_tx
    import cdc_pkg::*;
#(
    parameter int unsigned DW = CDC_DW_DEFAULT,
    parameter int unsigned PS = CDC_PS_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          tx_req,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ack,
    output logic          done,
    output logic          busy
);

    cdc_state_e    state_q, state_d;
    logic          tx_req_q, tx_req_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          done_q, done_d;
    logic          ack_s;

    cdc_sync_sreset #(
        .PS(PS)
    ) u_ack_sync (
        .clk  (clk),
        .reset(reset),
        .din  (tx_ack),
        .dout (ack_s)
    );

    // Next-state logic; tx_data only ever loads on an IDLE accept.
    always_comb begin
        state_d   = state_q;
        tx_req_d  = tx_req_q;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    tx_data_d = in_data;
                    tx_req_d  = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    state_d  = DROP;
                end
            end
            DROP: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_req_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_req_q  <= tx_req_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx_req   = tx_req_q;
    assign tx_data  = tx_data_q;
    assign done     = done_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Self-checking bench for cdc_hs_tx: protocol-level model, scoreboard, directed and jittered tests.
module tb_cdc_hs_tx;

    localparam int unsigned DW = 32;
    localparam int unsigned PS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          tx_req;
    logic [DW-1:0] tx_data;
    logic          tx_ack = 1'b0;
    logic          done;
    logic          busy;

    cdc_hs_tx #(.DW(DW), .PS(PS)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .tx_ack  (tx_ack),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Protocol-level model: a transfer is "open" from accept until the ack has been seen
    // high then low through a PS-cycle delay line.
    logic          m_open = 1'b0;
    logic          m_req = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic          m_done = 1'b0;
    logic [PS-1:0] ack_hist = '0;
    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] rise_log[$];
    bit            chk_en = 1'b0;
    int            done_cnt = 0;

    always @(posedge clk) begin
        logic ack_seen;
        ack_seen = ack_hist[PS-1];
        if (reset) begin
            m_open = 1'b0; m_req = 1'b0; m_data = '0; m_done = 1'b0; ack_hist = '0;
        end else begin
            m_done = 1'b0;
            if (!m_open) begin
                if (in_valid) begin
                    m_open = 1'b1; m_req = 1'b1; m_data = in_data;
                    acc_q.push_back(in_data);
                end
            end else if (m_req) begin
                if (ack_seen) m_req = 1'b0;
            end else if (!ack_seen) begin
                m_open = 1'b0; m_done = 1'b1;
            end
            ack_hist = {ack_hist[PS-2:0], tx_ack};
        end
    end

    // Per-cycle compare against the model, plus in-order data scoreboard on each req rise.
    logic          prev_req = 1'b0;
    logic [DW-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_req", 32'(tx_req), 32'(m_req));
            chk("tx_data", tx_data, m_data);
            chk("done", 32'(done), 32'(m_done));
            chk("busy", 32'(busy), 32'(m_open));
            chk("in_ready", 32'(in_ready), 32'(!m_open));
            if (prev_req && tx_req) chk("data_stable", tx_data, prev_data);
            if (tx_req && !prev_req) begin
                rise_log.push_back(tx_data);
                if (acc_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
                else chk("sb_order", tx_data, acc_q.pop_front());
            end
            if (done) done_cnt++;
            prev_req  = tx_req;
            prev_data = tx_data;
        end
    end

    // Receiver emulation: 0 = manual, 1 = follow req after 1 time unit, 2 = jittered follow.
    int auto_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            if (auto_mode == 1) begin
                #1 tx_ack = tx_req;
            end else if (auto_mode == 2) begin
                int d;
                d = int'($urandom_range(0, 5));
                d = (d < 3) ? (7 + d) : (8 + d);
                #(d) tx_ack = tx_req;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] w);
        bit ok;
        bit rdy;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 500; i++) begin
            rdy = in_ready;
            step();
            if (rdy) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic wait_req(input logic lvl, output int cyc);
        cyc = 0;
        while (tx_req !== lvl && cyc < 100) begin step(); cyc++; end
        if (cyc >= 100) chk("wait_req_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin step(); cyc++; end
        if (cyc >= 100) chk("wait_done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int c;
        int d0;

        // Reset held 3 cycles with valid and ack asserted.
        reset = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; tx_ack = 1'b1;
        step();
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_req", 32'(tx_req), 32'd0);
            chk("rst_data", tx_data, 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            if (i < 2) step();
        end
        reset = 1'b0; in_valid = 1'b0; tx_ack = 1'b0;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        repeat (3) step();

        // Single transfer with hand-timed receiver.
        send(32'hDEAD_BEEF);
        chk("single_req_rise", 32'(tx_req), 32'd1);
        chk("single_data", tx_data, 32'hDEAD_BEEF);
        step();
        tx_ack = 1'b1;
        wait_req(1'b0, c);
        chk("req_fall_lat", 32'(c), 32'(PS + 1));
        step();
        tx_ack = 1'b0;
        wait_done(c);
        chk("done_lat", 32'(c), 32'(PS + 1));
        step();
        chk("done_one_cycle", 32'(done), 32'd0);
        repeat (2) step();

        // Back-to-back words with an auto-responding receiver.
        auto_mode = 1;
        rise_log.delete();
        d0 = done_cnt;
        for (int w = 1; w <= 4; w++) send(32'(w));
        c = 0;
        while ((done_cnt - d0) < 4 && c < 200) begin step(); c++; end
        repeat (3) step();
        chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd4);
        chk("b2b_log_len", 32'(rise_log.size()), 32'd4);
        for (int w = 0; w < 4 && w < rise_log.size(); w++) chk("b2b_seq", rise_log[w], 32'(w + 1));
        auto_mode = 0;
        repeat (3) step();
        tx_ack = 1'b0;
        repeat (4) step();

        // Slow receiver: ack held low; a competing word must not be captured.
        send(32'h0000_0011);
        in_valid = 1'b1; in_data = 32'hAAAA_55AA;
        for (int i = 0; i < 50; i++) begin
            step();
            if (i % 10 == 0) begin
                chk("slow_req", 32'(tx_req), 32'd1);
                chk("slow_ready", 32'(in_ready), 32'd0);
            end
        end
        chk("slow_data_held", tx_data, 32'h0000_0011);
        in_valid = 1'b0;
        tx_ack = 1'b1;
        wait_req(1'b0, c);
        tx_ack = 1'b0;
        wait_done(c);
        repeat (3) step();

        // Reset while in DROP with ack still high.
        send(32'h0000_0022);
        tx_ack = 1'b1;
        wait_req(1'b0, c);
        chk("in_drop_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        d0 = done_cnt;
        chk("mrst_req", 32'(tx_req), 32'd0);
        chk("mrst_data", tx_data, 32'd0);
        send(32'h0000_0005);
        chk("mrst_next_req", 32'(tx_req), 32'd1);
        chk("mrst_next_data", tx_data, 32'h0000_0005);
        wait_req(1'b0, c);
        tx_ack = 1'b0;
        wait_done(c);
        step();
        chk("mrst_one_done", 32'(done_cnt - d0), 32'd1);
        repeat (3) step();

        // Jittered receiver over many random transfers.
        auto_mode = 2;
        d0 = done_cnt;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) step();
            send($urandom);
        end
        c = 0;
        while ((done_cnt - d0) < 1000 && c < 500) begin step(); c++; end
        repeat (5) step();
        chk("jit_done_cnt", 32'(done_cnt - d0), 32'd1000);
        chk("jit_sb_drained", 32'(acc_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
